counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_seq_pkg.sv | 21 ++
 rtl/counter_sequencer.sv | 152 +++++++++++++++
 tb/tb_counter_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_TIMEOUT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/counter_sequencer.sv
// Sequences one job on an external counter: load config, pulse reset, run until done/timeout/abort, report.
// Latency: accept -> LOAD (1 cycle) -> RUN (1..TIMEOUT cycles) -> RESP; response is held until consumed.
// Backpressure: cmd_ready_o only in IDLE; RESP holds all rsp_* stable until rsp_ready_i.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_init_i,
  input  logic [WIDTH-1:0] cmd_inc_i,
  input  logic [WIDTH-1:0] cmd_target_i,
  input  logic             abort_i,
  output logic             counter_reset_o,
  output logic             counter_enable_o,
  output logic [WIDTH-1:0] counter_init_o,
  output logic [WIDTH-1:0] counter_inc_o,
  output logic [WIDTH-1:0] counter_target_o,
  input  logic [WIDTH-1:0] counter_value_i,
  input  logic             counter_done_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_value_o,
  output logic [7:0]       rsp_cycles_o,
  output logic             rsp_timeout_o,
  output logic             rsp_abort_o
);

  // RUN cycle count seen on the cycle that must give up (count is pre-increment).
  localparam logic [7:0] LP_LAST_CYCLE = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_exit_abort;
  logic             w_exit_done;
  logic             w_exit_timeout;
  logic             w_exit;

  logic [WIDTH-1:0] r_init;
  logic [WIDTH-1:0] r_inc;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_value;
  logic [7:0]       r_cycles;
  logic             r_timeout;
  logic             r_abort;

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs; abort beats done, done beats timeout.
  always_comb begin
    w_next_state     = r_state;
    w_accept         = 1'b0;
    w_exit_abort     = 1'b0;
    w_exit_done      = 1'b0;
    w_exit_timeout   = 1'b0;
    cmd_ready_o      = 1'b0;
    counter_reset_o  = 1'b0;
    counter_enable_o = 1'b0;
    rsp_valid_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_accept     = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        counter_reset_o = 1'b1;
        if (abort_i) begin
          w_exit_abort = 1'b1;
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        counter_enable_o = 1'b1;
        if (abort_i) begin
          w_exit_abort = 1'b1;
        end else if (counter_done_i) begin
          w_exit_done = 1'b1;
        end else if (r_cycles == LP_LAST_CYCLE) begin
          w_exit_timeout = 1'b1;
        end
        if (w_exit_abort || w_exit_done || w_exit_timeout) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_exit = w_exit_abort | w_exit_done | w_exit_timeout;

  // Job config, RUN cycle count and latched result; result only changes on a RUN/LOAD exit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_init    <= '0;
      r_inc     <= '0;
      r_target  <= '0;
      r_value   <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_init   <= cmd_init_i;
        r_inc    <= cmd_inc_i;
        r_target <= cmd_target_i;
        r_cycles <= '0;
      end
      if (r_state == ST_RUN) begin
        r_cycles <= sat_inc8(r_cycles);
      end
      if (w_exit) begin
        r_value   <= counter_value_i;
        r_timeout <= w_exit_timeout;
        r_abort   <= w_exit_abort;
      end
    end
  end

  assign counter_init_o   = r_init;
  assign counter_inc_o    = r_inc;
  assign counter_target_o = r_target;
  assign rsp_value_o      = r_value;
  assign rsp_cycles_o     = r_cycles;
  assign rsp_timeout_o    = r_timeout;
  assign rsp_abort_o      = r_abort;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with a behavioural downstream counter and a job-level reference model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready_i low for random spans.
module tb_counter_sequencer;

  localparam int W  = 4;
  localparam int TO = 32;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [W-1:0] cmd_init_i, cmd_inc_i, cmd_target_i;
  logic         abort_i;
  logic         counter_reset_o, counter_enable_o;
  logic [W-1:0] counter_init_o, counter_inc_o, counter_target_o;
  logic [W-1:0] counter_value_i;
  logic         counter_done_i;
  logic         rsp_valid_o, rsp_ready_i;
  logic [W-1:0] rsp_value_o;
  logic [7:0]   rsp_cycles_o;
  logic         rsp_timeout_o, rsp_abort_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  counter_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_init_i(cmd_init_i), .cmd_inc_i(cmd_inc_i), .cmd_target_i(cmd_target_i),
    .abort_i(abort_i),
    .counter_reset_o(counter_reset_o), .counter_enable_o(counter_enable_o),
    .counter_init_o(counter_init_o), .counter_inc_o(counter_inc_o), .counter_target_o(counter_target_o),
    .counter_value_i(counter_value_i), .counter_done_i(counter_done_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_value_o(rsp_value_o), .rsp_cycles_o(rsp_cycles_o),
    .rsp_timeout_o(rsp_timeout_o), .rsp_abort_o(rsp_abort_o)
  );

  // Downstream counter stand-in: loads init on reset pulse, adds inc when enabled, done at target.
  logic         tb_use  = 1'b0;
  logic [W-1:0] tb_val  = '0;
  logic         tb_done = 1'b0;
  logic [W-1:0] m_cnt   = '0;
  always @(posedge clk_i) begin
    if (counter_reset_o)       m_cnt <= counter_init_o;
    else if (counter_enable_o) m_cnt <= m_cnt + counter_inc_o;
  end
  assign counter_value_i = tb_use ? m_cnt : tb_val;
  assign counter_done_i  = tb_use ? (m_cnt == counter_target_o) : tb_done;

  // All outputs packed; under reset only cmd_ready_o (the MSB) may be 1.
  logic [29:0] w_outs;
  assign w_outs = {cmd_ready_o, counter_reset_o, counter_enable_o, counter_init_o, counter_inc_o,
                   counter_target_o, rsp_valid_o, rsp_value_o, rsp_cycles_o, rsp_timeout_o, rsp_abort_o};
  localparam logic [29:0] RESET_OUTS = 30'h2000_0000;

  // Observations returned by run_job.
  bit         ob_rdy, ob_cfg, ob_stable, ob_idle;
  int         ob_lat, ob_rst, ob_en;
  logic [3:0] ob_val;
  logic [7:0] ob_cyc;
  logic       ob_to, ob_ab;

  // Job-level reference: walk RUN cycles k=1..TO applying abort > done > timeout.
  // abort_a: -1 none, 0 during LOAD, k during RUN cycle k. done_k: forced done RUN cycle (0 none).
  task automatic ref_model(input logic [3:0] init, inc, tgt, input bit use_cnt, input logic [3:0] fixv,
                           input int done_k, input int abort_a,
                           output logic [3:0] e_val, output int e_cyc, output logic e_to, output logic e_ab);
    logic [3:0] v;
    bit fin;
    e_val = '0; e_cyc = 0; e_to = 1'b0; e_ab = 1'b0; fin = 0;
    if (abort_a == 0) begin
      e_ab = 1'b1; e_val = fixv; fin = 1;
    end
    for (int k = 1; k <= TO && !fin; k++) begin
      v = use_cnt ? 4'(int'(init) + (k - 1) * int'(inc)) : fixv;
      if (k == abort_a) begin
        e_ab = 1'b1; e_cyc = k; e_val = v; fin = 1;
      end else if (use_cnt ? (v == tgt) : (k == done_k)) begin
        e_cyc = k; e_val = v; fin = 1;
      end else if (k == TO) begin
        e_to = 1'b1; e_cyc = k; e_val = v; fin = 1;
      end
    end
  endtask

  // Drives one job from IDLE (called just after a falling edge) through its response handshake.
  // ob_lat is the falling-edge index (1 = LOAD) at which rsp_valid_o first appears, -1 if never.
  task automatic run_job(input logic [3:0] init, inc, tgt, input bit use_cnt, input logic [3:0] fixv,
                         input int done_k, input int abort_a, input int hold,
                         input bit pend, input logic [3:0] p_init, p_inc, p_tgt);
    logic [13:0] snap;
    ob_lat = -1; ob_rst = 0; ob_en = 0; ob_val = '0; ob_cyc = '0; ob_to = 0; ob_ab = 0;
    ob_cfg = 0; ob_stable = 1; ob_idle = 0;
    tb_use = use_cnt; tb_val = fixv; tb_done = 0;
    ob_rdy = cmd_ready_o;
    cmd_init_i = init; cmd_inc_i = inc; cmd_target_i = tgt; cmd_valid_i = 1;
    @(negedge clk_i);
    cmd_valid_i = 0;
    for (int j = 1; j <= TO + 10; j++) begin
      if (j > 1) @(negedge clk_i);
      if (rsp_valid_o) begin
        ob_lat = j;
        break;
      end
      ob_rst += int'(counter_reset_o);
      ob_en  += int'(counter_enable_o);
      abort_i = (abort_a >= 0) && (j == abort_a + 1);
      tb_done = (done_k > 0) && (j == done_k + 1);
    end
    abort_i = 0; tb_done = 0;
    if (ob_lat < 0) return;
    ob_val = rsp_value_o; ob_cyc = rsp_cycles_o; ob_to = rsp_timeout_o; ob_ab = rsp_abort_o;
    ob_cfg = (counter_init_o == init) && (counter_inc_o == inc) && (counter_target_o == tgt);
    snap = {rsp_value_o, rsp_cycles_o, rsp_timeout_o, rsp_abort_o};
    if (pend) begin
      cmd_init_i = p_init; cmd_inc_i = p_inc; cmd_target_i = p_tgt; cmd_valid_i = 1;
    end
    for (int h = 0; h < hold; h++) begin
      abort_i = 1'($urandom);
      @(negedge clk_i);
      if ({rsp_value_o, rsp_cycles_o, rsp_timeout_o, rsp_abort_o} !== snap || rsp_valid_o !== 1'b1 ||
          cmd_ready_o !== 1'b0 || counter_init_o !== init || counter_inc_o !== inc ||
          counter_target_o !== tgt || counter_enable_o !== 1'b0)
        ob_stable = 0;
    end
    abort_i = 0; rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    ob_idle = (cmd_ready_o === 1'b1) && (rsp_valid_o === 1'b0) && (counter_init_o === init);
  endtask

  task automatic test_reset();
    reset_i = 1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (w_outs !== RESET_OUTS) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", w_outs, RESET_OUTS);
    end
    reset_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: ready=%b valid=%b expected 1/0", cmd_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_counter_job();
    // 0,3,6,9,C,F: done seen in RUN cycle 6.
    run_job(4'h0, 4'h3, 4'hF, 1, 4'h0, 0, -1, 0, 0, 4'h0, 4'h0, 4'h0);
    n_checks++; if (ob_rdy !== 1'b1) begin n_fail++; $display("FAIL cnt_ready: got %b expected 1", ob_rdy); end
    n_checks++; if (ob_val !== 4'hF) begin n_fail++; $display("FAIL cnt_value: got %h expected f", ob_val); end
    n_checks++; if ({ob_to, ob_ab} !== 2'b00) begin n_fail++; $display("FAIL cnt_flags: got %b expected 00", {ob_to, ob_ab}); end
    n_checks++; if (ob_rst !== 1) begin n_fail++; $display("FAIL cnt_reset_pulse: got %0d cycles expected 1", ob_rst); end
    n_checks++; if (ob_cyc !== 8'd6 || ob_lat !== 8) begin n_fail++; $display("FAIL cnt_cycles: got %0d lat %0d expected 6 lat 8", ob_cyc, ob_lat); end
    n_checks++; if (!ob_cfg || !ob_idle) begin n_fail++; $display("FAIL cnt_cfg_idle: got cfg=%b idle=%b expected 1/1", ob_cfg, ob_idle); end
  endtask

  task automatic test_done_third();
    run_job(4'h1, 4'h1, 4'h0, 0, 4'hA, 3, -1, 0, 0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (ob_cyc !== 8'd3 || ob_to !== 1'b0 || ob_ab !== 1'b0 || ob_val !== 4'hA || ob_lat !== 5 || ob_en !== 3) begin
      n_fail++; $display("FAIL done_third: got cyc=%0d to=%b ab=%b val=%h lat=%0d en=%0d expected 3 0 0 a 5 3",
                         ob_cyc, ob_to, ob_ab, ob_val, ob_lat, ob_en);
    end
  endtask

  task automatic test_timeout();
    run_job(4'h0, 4'h0, 4'hF, 1, 4'h0, 0, -1, 0, 0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (ob_to !== 1'b1 || ob_cyc !== 8'd32 || ob_ab !== 1'b0 || ob_val !== 4'h0 || ob_lat !== 34) begin
      n_fail++; $display("FAIL timeout_32: got to=%b cyc=%0d ab=%b val=%h lat=%0d expected 1 32 0 0 34",
                         ob_to, ob_cyc, ob_ab, ob_val, ob_lat);
    end
    // Done on the very cycle the timeout would fire: done wins.
    run_job(4'h0, 4'h0, 4'h0, 0, 4'h5, 32, -1, 1, 0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (ob_to !== 1'b0 || ob_cyc !== 8'd32 || ob_val !== 4'h5) begin
      n_fail++; $display("FAIL done_vs_timeout: got to=%b cyc=%0d val=%h expected 0 32 5", ob_to, ob_cyc, ob_val);
    end
  endtask

  task automatic test_abort();
    run_job(4'h0, 4'h0, 4'h0, 0, 4'h7, 2, 2, 0, 0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (ob_ab !== 1'b1 || ob_to !== 1'b0 || ob_cyc !== 8'd2 || ob_val !== 4'h7 || ob_lat !== 4) begin
      n_fail++; $display("FAIL abort_with_done: got ab=%b to=%b cyc=%0d val=%h lat=%0d expected 1 0 2 7 4",
                         ob_ab, ob_to, ob_cyc, ob_val, ob_lat);
    end
    run_job(4'h0, 4'h0, 4'h0, 0, 4'h3, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (ob_ab !== 1'b1 || ob_cyc !== 8'd0 || ob_val !== 4'h3 || ob_lat !== 2 || ob_en !== 0) begin
      n_fail++; $display("FAIL abort_in_load: got ab=%b cyc=%0d val=%h lat=%0d en=%0d expected 1 0 3 2 0",
                         ob_ab, ob_cyc, ob_val, ob_lat, ob_en);
    end
    run_job(4'h0, 4'h0, 4'h0, 0, 4'hC, 0, 32, 0, 0, 4'h0, 4'h0, 4'h0);
    n_checks++;
    if (ob_ab !== 1'b1 || ob_to !== 1'b0 || ob_cyc !== 8'd32) begin
      n_fail++; $display("FAIL abort_vs_timeout: got ab=%b to=%b cyc=%0d expected 1 0 32", ob_ab, ob_to, ob_cyc);
    end
    abort_i = 1;
    @(negedge clk_i);
    abort_i = 0;
    n_checks++;
    if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_in_idle: got ready=%b valid=%b expected 1 0", cmd_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    // 2,3,4,5 -> done in RUN cycle 4; a second job waits on cmd_valid_i through a 5-cycle stall.
    run_job(4'h2, 4'h1, 4'h5, 1, 4'h0, 0, -1, 5, 1, 4'h9, 4'h2, 4'h4);
    n_checks++;
    if (ob_val !== 4'h5 || ob_cyc !== 8'd4 || ob_to !== 1'b0 || ob_ab !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got val=%h cyc=%0d to=%b ab=%b expected 5 4 0 0", ob_val, ob_cyc, ob_to, ob_ab);
    end
    n_checks++;
    if (!ob_stable || !ob_idle) begin
      n_fail++; $display("FAIL b2b_hold: got stable=%b idle=%b expected 1 1", ob_stable, ob_idle);
    end
    @(negedge clk_i);
    cmd_valid_i = 0;
    n_checks++;
    if ({counter_init_o, counter_inc_o, counter_target_o} !== 12'h924 || counter_reset_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_accept: got cfg=%h rst=%b ready=%b expected 924 1 0",
                         {counter_init_o, counter_inc_o, counter_target_o}, counter_reset_o, cmd_ready_o);
    end
    abort_i = 1;
    @(negedge clk_i);
    abort_i = 0;
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_abort_o !== 1'b1 || rsp_cycles_o !== 8'd0) begin
      n_fail++; $display("FAIL b2b_second_abort: got valid=%b ab=%b cyc=%0d expected 1 1 0", rsp_valid_o, rsp_abort_o, rsp_cycles_o);
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
  endtask

  task automatic test_reset_mid_run();
    bit quiet;
    tb_use = 0; tb_done = 0; tb_val = 4'h6;
    cmd_init_i = 4'h1; cmd_inc_i = 4'h2; cmd_target_i = 4'h3; cmd_valid_i = 1;
    @(negedge clk_i);
    cmd_valid_i = 0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (counter_enable_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_running: got enable=%b expected 1", counter_enable_o);
    end
    reset_i = 1;
    #1;
    n_checks++;
    if (w_outs !== RESET_OUTS) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h expected %h", w_outs, RESET_OUTS);
    end
    @(negedge clk_i);
    reset_i = 0;
    quiet = 1;
    repeat (5) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++; $display("FAIL rst_mid_no_resp: got quiet=%b expected 1", quiet);
    end
  endtask

  task automatic test_random();
    logic [3:0] init, inc, tgt, fixv, e_val;
    bit use_cnt;
    int done_k, abort_a, hold, e_cyc;
    logic e_to, e_ab;
    for (int n = 0; n < 40; n++) begin
      init = 4'($urandom); inc = 4'($urandom); tgt = 4'($urandom); fixv = 4'($urandom);
      use_cnt = 1'($urandom);
      done_k  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 34));
      abort_a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(use_cnt ? 1 : 0, 34)) : -1;
      hold    = int'($urandom_range(0, 3));
      ref_model(init, inc, tgt, use_cnt, fixv, done_k, abort_a, e_val, e_cyc, e_to, e_ab);
      run_job(init, inc, tgt, use_cnt, fixv, done_k, abort_a, hold, 0, 4'h0, 4'h0, 4'h0);
      n_checks++;
      if ({ob_val, ob_cyc, ob_to, ob_ab} !== {e_val, 8'(e_cyc), e_to, e_ab}) begin
        n_fail++; $display("FAIL rand_result[%0d]: got val=%h cyc=%0d to=%b ab=%b expected val=%h cyc=%0d to=%b ab=%b",
                           n, ob_val, ob_cyc, ob_to, ob_ab, e_val, e_cyc, e_to, e_ab);
      end
      n_checks++;
      if (ob_lat !== e_cyc + 2 || ob_en !== e_cyc || ob_rst !== 1) begin
        n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d en=%0d rst=%0d expected %0d %0d 1",
                           n, ob_lat, ob_en, ob_rst, e_cyc + 2, e_cyc);
      end
      n_checks++;
      if (!ob_rdy || !ob_cfg || !ob_stable || !ob_idle) begin
        n_fail++; $display("FAIL rand_handshake[%0d]: got rdy=%b cfg=%b stable=%b idle=%b expected all 1",
                           n, ob_rdy, ob_cfg, ob_stable, ob_idle);
      end
    end
  endtask

  initial begin
    reset_i = 1; cmd_valid_i = 0; cmd_init_i = '0; cmd_inc_i = '0; cmd_target_i = '0;
    abort_i = 0; rsp_ready_i = 0;
    test_reset();
    test_counter_job();
    test_done_third();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
